bmc_soft_pipe: RTL and testbench

- Parametrised branch-metric unit for the Viterbi decoder. It is the successor to the fixed rate-1/2 hard-decision BMC.
- Accepts one received symbol per transfer: RATE_N code bits, each an SW-bit soft value.
- Computes the metric for every one of the 2^RATE_N candidate codewords, supporting soft or hard decision and per-bit erasure for punctured codes.
- Delivers the metrics, plus the index of the minimum metric, through a 2-stage valid/ready pipeline to the ACS array.

---
 rtl/bmc_soft_pipe.sv | 133 +++++++++++++
 tb/tb_bmc_soft_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_soft_pipe.sv
//------------------------------------------------------------------------------
// Module   : bmc_soft_pipe
// Brief    : Soft/hard branch-metric unit with erasure support and 2-stage
//            valid/ready pipeline feeding the Viterbi ACS array.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bmc_soft_pipe #(
   parameter int RATE_N = 2,
   parameter int SW     = 3,
   parameter int BMW    = SW + $clog2(RATE_N),
   parameter int CNT_W  = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_valid,
   output logic                           i_ready,
   input  logic [RATE_N*SW-1:0]           i_soft,
   input  logic [RATE_N-1:0]              i_erase,
   input  logic                           i_last,
   input  logic                           hard_mode,
   output logic                           o_valid,
   input  logic                           o_ready,
   output logic [(1<<RATE_N)*BMW-1:0]     o_bm,
   output logic [RATE_N-1:0]              o_min_idx,
   output logic                           o_last,
   output logic [CNT_W-1:0]               o_sym_cnt
);

   localparam int            c_NCW  = 1 << RATE_N;
   localparam logic [SW-1:0] c_SMAX = '1;

   logic                    w_en1;
   logic                    w_en2;
   logic [RATE_N*SW-1:0]    w_d0;
   logic [RATE_N*SW-1:0]    w_d1;
   logic [c_NCW*BMW-1:0]    w_bm;
   logic [RATE_N-1:0]       w_min_idx;

   logic                    r_s1_valid;
   logic                    r_s1_last;
   logic [RATE_N*SW-1:0]    r_s1_d0;
   logic [RATE_N*SW-1:0]    r_s1_d1;

   // Stage 2 frees up on output transfer or when empty; stage 1 follows.
   assign w_en2   = !o_valid || o_ready;
   assign w_en1   = !r_s1_valid || w_en2;
   assign i_ready = w_en1;

   // d0: distance to an expected 0, d1: distance to an expected 1.
   always_comb begin
      w_d0 = '0;
      w_d1 = '0;
      for (int j = 0; j < RATE_N; j++) begin
         if (!i_erase[j]) begin
            if (hard_mode) begin
               w_d0[j*SW +: SW] = SW'(i_soft[j*SW + SW - 1]);
               w_d1[j*SW +: SW] = SW'(!i_soft[j*SW + SW - 1]);
            end else begin
               w_d0[j*SW +: SW] = i_soft[j*SW +: SW];
               w_d1[j*SW +: SW] = c_SMAX - i_soft[j*SW +: SW];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_d0    <= '0;
         r_s1_d1    <= '0;
      end else if (w_en1) begin
         r_s1_valid <= i_valid;
         if (i_valid) begin
            r_s1_last <= i_last;
            r_s1_d0   <= w_d0;
            r_s1_d1   <= w_d1;
         end
      end
   end

   // Strict less-than while scanning upward keeps ties on the lowest index.
   always_comb begin
      logic [BMW-1:0] acc;
      logic [BMW-1:0] min_val;
      w_bm      = '0;
      w_min_idx = '0;
      acc       = '0;
      min_val   = '0;
      for (int k = 0; k < c_NCW; k++) begin
         acc = '0;
         for (int j = 0; j < RATE_N; j++) begin
            if (((k >> j) & 1) == 1)
               acc = acc + BMW'(r_s1_d1[j*SW +: SW]);
            else
               acc = acc + BMW'(r_s1_d0[j*SW +: SW]);
         end
         w_bm[k*BMW +: BMW] = acc;
         if (k == 0 || acc < min_val) begin
            min_val   = acc;
            w_min_idx = RATE_N'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid   <= 1'b0;
         o_last    <= 1'b0;
         o_bm      <= '0;
         o_min_idx <= '0;
      end else if (w_en2) begin
         o_valid <= r_s1_valid;
         if (r_s1_valid) begin
            o_last    <= r_s1_last;
            o_bm      <= w_bm;
            o_min_idx <= w_min_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         o_sym_cnt <= '0;
      else if (o_valid && o_ready)
         o_sym_cnt <= o_last ? '0 : o_sym_cnt + CNT_W'(1);
   end

endmodule

`default_nettype wire

// File: tb/tb_bmc_soft_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_bmc_soft_pipe
// Brief    : Directed scoreboard bench for bmc_soft_pipe (RATE_N=2, SW=3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bmc_soft_pipe;

   localparam int RATE_N = 2;
   localparam int SW     = 3;
   localparam int BMW    = 4;
   localparam int CNT_W  = 8;
   localparam int NCW    = 4;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  i_valid;
   logic                  i_ready;
   logic [RATE_N*SW-1:0]  i_soft;
   logic [RATE_N-1:0]     i_erase;
   logic                  i_last;
   logic                  hard_mode;
   logic                  o_valid;
   logic                  o_ready;
   logic [NCW*BMW-1:0]    o_bm;
   logic [RATE_N-1:0]     o_min_idx;
   logic                  o_last;
   logic [CNT_W-1:0]      o_sym_cnt;

   bmc_soft_pipe #(
      .RATE_N (RATE_N),
      .SW     (SW),
      .BMW    (BMW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .i_soft    (i_soft),
      .i_erase   (i_erase),
      .i_last    (i_last),
      .hard_mode (hard_mode),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_bm      (o_bm),
      .o_min_idx (o_min_idx),
      .o_last    (o_last),
      .o_sym_cnt (o_sym_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCW*BMW-1:0] bm;
      logic [RATE_N-1:0]  idx;
      logic               last;
      logic [CNT_W-1:0]   cnt;
   } exp_t;

   exp_t             sb[$];
   int               total = 0;
   int               bad = 0;
   logic [CNT_W-1:0] exp_cnt = '0;
   bit               mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [NCW*BMW-1:0] pk(input int k0, input int k1, input int k2, input int k3);
      return {k3[3:0], k2[3:0], k1[3:0], k0[3:0]};
   endfunction

   // Present one symbol until accepted, then queue its hand-computed response.
   task automatic send(input logic [SW-1:0] r0, input logic [SW-1:0] r1,
                       input logic [1:0] er, input logic hm, input logic lst,
                       input logic [NCW*BMW-1:0] ebm, input logic [RATE_N-1:0] eidx);
      bit   acc;
      int   n;
      exp_t e;
      i_valid   = 1'b1;
      i_soft    = {r1, r0};
      i_erase   = er;
      hard_mode = hm;
      i_last    = lst;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = i_ready;
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_accept", 32'(acc), 32'd1);
      if (acc) begin
         e.bm   = ebm;
         e.idx  = eidx;
         e.last = lst;
         e.cnt  = exp_cnt;
         exp_cnt = lst ? '0 : exp_cnt + 8'd1;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      i_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: pops on every output transfer and checks hold-stability on stalls.
   initial begin
      logic [NCW*BMW-1:0] pbm;
      logic [RATE_N-1:0]  pidx;
      logic               plast;
      logic [CNT_W-1:0]   pcnt;
      bit                 pstall;
      exp_t               e;
      pbm = '0; pidx = '0; plast = 1'b0; pcnt = '0; pstall = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            pstall = 1'b0;
         end else begin
            if (pstall)
               chk("hold_stable", 32'({o_valid, o_last, o_min_idx, o_sym_cnt, o_bm}),
                   32'({1'b1, plast, pidx, pcnt, pbm}));
            if (o_valid && o_ready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_out: got bm=0x%0h expected no output", o_bm);
               end else begin
                  e = sb.pop_front();
                  chk("o_bm", 32'(o_bm), 32'(e.bm));
                  chk("o_min_idx", 32'(o_min_idx), 32'(e.idx));
                  chk("o_last", 32'(o_last), 32'(e.last));
                  chk("o_sym_cnt", 32'(o_sym_cnt), 32'(e.cnt));
               end
            end
            pstall = o_valid && !o_ready;
            pbm = o_bm; pidx = o_min_idx; plast = o_last; pcnt = o_sym_cnt;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      i_valid = 1'b0; i_soft = '0; i_erase = '0; i_last = 1'b0; hard_mode = 1'b0;
      o_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_bm", 32'(o_bm), 32'd0);
      chk("rst_o_min_idx", 32'(o_min_idx), 32'd0);
      chk("rst_o_last", 32'(o_last), 32'd0);
      chk("rst_o_sym_cnt", 32'(o_sym_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_i_ready", 32'(i_ready), 32'd1);
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Metric vectors; frame of 3 ends on the third, second frame of 3 follows.
      send(3'd7, 3'd0, 2'b00, 1'b0, 1'b0, pk(7, 0, 14, 7), 2'd1);
      send(3'd7, 3'd0, 2'b00, 1'b1, 1'b0, pk(1, 0, 2, 1), 2'd1);
      send(3'd4, 3'd4, 2'b00, 1'b1, 1'b1, pk(2, 1, 1, 0), 2'd3);
      send(3'd7, 3'd0, 2'b10, 1'b0, 1'b0, pk(7, 0, 7, 0), 2'd1);
      send(3'd5, 3'd2, 2'b11, 1'b0, 1'b0, pk(0, 0, 0, 0), 2'd0);
      send(3'd0, 3'd7, 2'b00, 1'b1, 1'b1, pk(1, 2, 0, 1), 2'd2);
      drain();

      // Backpressure: o_ready low for 3 cycles once both stages hold data.
      fork
         begin
            send(3'd3, 3'd5, 2'b00, 1'b0, 1'b0, pk(8, 9, 5, 6), 2'd2);
            send(3'd4, 3'd3, 2'b00, 1'b0, 1'b0, pk(7, 6, 8, 7), 2'd1);
            send(3'd0, 3'd0, 2'b00, 1'b0, 1'b0, pk(0, 7, 7, 14), 2'd0);
            send(3'd7, 3'd7, 2'b00, 1'b0, 1'b0, pk(14, 7, 7, 0), 2'd3);
            i_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            o_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("bp_i_ready", 32'(i_ready), 32'd0);
               chk("bp_o_valid", 32'(o_valid), 32'd1);
               @(posedge clk);
            end
            #1;
            o_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset with both stages full and the output stalled.
      o_ready = 1'b0;
      send(3'd7, 3'd0, 2'b00, 1'b0, 1'b0, pk(7, 0, 14, 7), 2'd1);
      send(3'd0, 3'd7, 2'b00, 1'b0, 1'b0, pk(7, 14, 0, 7), 2'd2);
      i_valid = 1'b0;
      #1;
      chk("full_o_valid", 32'(o_valid), 32'd1);
      chk("full_i_ready", 32'(i_ready), 32'd0);
      chk("pre_rst_cnt", 32'(o_sym_cnt), 32'd4);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_o_valid", 32'(o_valid), 32'd0);
      chk("arst_o_sym_cnt", 32'(o_sym_cnt), 32'd0);
      chk("arst_o_bm", 32'(o_bm), 32'd0);
      chk("arst_i_ready", 32'(i_ready), 32'd1);
      sb.delete();
      exp_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      send(3'd3, 3'd5, 2'b00, 1'b0, 1'b1, pk(8, 9, 5, 6), 2'd2);
      i_valid = 1'b0;
      @(negedge clk);
      chk("lat_stage1_only", 32'(o_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_two_cycles", 32'(o_valid), 32'd1);
      @(posedge clk);
      #1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
